// File: rtl/riscv_pipe_chain_pkg.sv
// Shared helpers for the elastic pipeline chain: popcount, saturating increment
// and the occupancy width calculation.
package riscv_pipe_chain_pkg;

    // Widest vector the helper functions accept (stage count and counter width).
    localparam int unsigned MaxW = 64;

    // Occupancy must represent 0..STAGES+1 (all stages plus the skid entry).
    function automatic int unsigned occ_width(input int unsigned stages);
        return $clog2(stages + 2);
    endfunction

    function automatic int unsigned popcount(input logic [MaxW-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(MaxW); i++) begin
            if (vec[i]) n++;
        end
        return n;
    endfunction

    // Increment, holding at all-ones of a w-bit counter.
    function automatic logic [MaxW-1:0] sat_inc(input logic [MaxW-1:0] val, input int unsigned w);
        logic [MaxW-1:0] lim;
        lim = (w >= MaxW) ? '1 : ((64'd1 << w) - 64'd1);
        return (val >= lim) ? val : val + 64'd1;
    endfunction

endpackage

// File: rtl/riscv_pipe_chain_if.sv
// Valid/ready/data stream bundle used on both ends of the pipeline chain.
interface riscv_pipe_chain_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/riscv_pipe_chain_skid_buf.sv
// One-entry skid buffer: catches an accepted input when stage 0 cannot take it,
// so the upstream ready can come straight from a flop.
module riscv_pipe_chain_skid_buf #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_full,
    output logic [DATA_W-1:0] o_data
);
    logic              r_full;
    logic [DATA_W-1:0] r_data;

    // Fill on push while empty, drain on pop, flush drops the held entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (r_full) begin
            if (i_pop) r_full <= 1'b0;
        end else if (i_push) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;
endmodule

// File: rtl/riscv_pipe_chain.sv
// Elastic pipeline-register chain with bubble collapse, per-stage flush,
// optional input skid buffer and stall/bubble performance counters.
module riscv_pipe_chain
    import riscv_pipe_chain_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned STAGES = 4,
    parameter  int unsigned SKID   = 1,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned OCC_W  = occ_width(STAGES)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    riscv_pipe_chain_if.slave          in_bus,
    riscv_pipe_chain_if.master         out_bus,
    input  logic                       i_flush_in,
    input  logic [STAGES-1:0]          i_flush,
    output logic [STAGES-1:0]          o_stage_valid,
    output logic [STAGES*DATA_W-1:0]   o_stage_data,
    output logic [OCC_W-1:0]           o_occupancy,
    input  logic                       i_cnt_clr,
    output logic [CNT_W-1:0]           o_stall_cnt,
    output logic [CNT_W-1:0]           o_bubble_cnt
);
    logic [STAGES-1:0]             w_v;
    logic [STAGES-1:0][DATA_W-1:0] w_d;
    logic [STAGES-1:0]             w_ve;
    logic [STAGES-1:0]             w_adv;
    logic                          w_in_ready;
    logic                          w_accept;
    logic                          w_src_valid;
    logic [DATA_W-1:0]             w_src_data;
    logic                          w_skid_full;
    logic                          w_out_valid;
    logic [CNT_W-1:0]              r_stall_cnt;
    logic [CNT_W-1:0]              r_bubble_cnt;

    // A flushed entry behaves as a bubble for the whole cycle.
    assign w_ve = w_v & ~i_flush;

    // Advance chain from the output side: a stage may load if the one after it
    // moves or if it currently holds a bubble.
    always_comb begin
        logic a;
        w_adv = '0;
        a = out_bus.ready | ~w_ve[STAGES-1];
        w_adv[STAGES-1] = a;
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            a = a | ~w_ve[i];
            w_adv[i] = a;
        end
    end

    assign w_accept = in_bus.valid & w_in_ready & ~i_flush_in;

    if (SKID != 0) begin : g_skid
        logic [DATA_W-1:0] w_skid_data;

        riscv_pipe_chain_skid_buf #(
            .DATA_W (DATA_W)
        ) u_skid (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_flush (i_flush_in),
            .i_push  (w_accept & ~w_adv[0]),
            .i_pop   (w_adv[0]),
            .i_data  (in_bus.data),
            .o_full  (w_skid_full),
            .o_data  (w_skid_data)
        );

        // Ready depends only on skid state so it never sees out_ready.
        assign w_in_ready  = ~w_skid_full & ~i_rst;
        assign w_src_valid = w_skid_full ? ~i_flush_in : w_accept;
        assign w_src_data  = w_skid_full ? w_skid_data : in_bus.data;
    end else begin : g_noskid
        assign w_skid_full = 1'b0;
        assign w_in_ready  = w_adv[0] & ~i_rst;
        assign w_src_valid = w_accept;
        assign w_src_data  = in_bus.data;
    end

    for (genvar gi = 0; gi < int'(STAGES); gi++) begin : g_stage
        logic              r_v;
        logic [DATA_W-1:0] r_d;
        logic              w_next_v;
        logic [DATA_W-1:0] w_next_d;

        if (gi == 0) begin : g_first
            assign w_next_v = w_src_valid;
            assign w_next_d = w_src_data;
        end else begin : g_mid
            assign w_next_v = w_ve[gi-1];
            assign w_next_d = w_d[gi-1];
        end

        // Load from the previous stage on advance; otherwise hold, letting flush clear valid.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_v <= 1'b0;
                r_d <= '0;
            end else if (w_adv[gi]) begin
                r_v <= w_next_v;
                r_d <= w_next_d;
            end else begin
                r_v <= w_ve[gi];
            end
        end

        assign w_v[gi] = r_v;
        assign w_d[gi] = r_d;
    end

    assign w_out_valid   = w_ve[STAGES-1];
    assign out_bus.valid = w_out_valid;
    assign out_bus.data  = w_d[STAGES-1];
    assign in_bus.ready  = w_in_ready;

    assign o_stage_valid = w_v;
    assign o_stage_data  = w_d;
    assign o_occupancy   = OCC_W'(popcount(MaxW'(w_v))) + OCC_W'(w_skid_full);

    // Saturating perf counters; clear takes priority over counting.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_out_valid && !out_bus.ready) begin
                r_stall_cnt <= CNT_W'(sat_inc(MaxW'(r_stall_cnt), CNT_W));
            end
            if (!w_out_valid && out_bus.ready) begin
                r_bubble_cnt <= CNT_W'(sat_inc(MaxW'(r_bubble_cnt), CNT_W));
            end
        end
    end

    assign o_stall_cnt  = r_stall_cnt;
    assign o_bubble_cnt = r_bubble_cnt;
endmodule
